// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control sequencer: steps fetch/decode/execute/memory/writeback, handshakes
// with a variable-latency unified memory, counts retired instructions and latches a sticky exception.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             zero_E,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IRWrite,
  output logic             Reg2Loc,
  output logic             AluSrc,
  output logic [3:0]       AluControl,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             exc,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] retire_count
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR,
    S_MEM_RD, S_WB_LD, S_MEM_WR, S_CB, S_UB, S_EXC
  } state_e;

  typedef enum logic [3:0] {
    OP_ILL, OP_LDUR, OP_STUR, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CBZ, OP_B
  } op_e;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               exc_q, exc_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   retire_q, retire_d;
  logic               retire;
  op_e                op_cls;
  logic [3:0]         alu_r;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    op_cls = OP_ILL;
    if      (opcode == 11'b11111000010)     op_cls = OP_LDUR;
    else if (opcode == 11'b11111000000)     op_cls = OP_STUR;
    else if (opcode == 11'b10001011000)     op_cls = OP_ADD;
    else if (opcode == 11'b11001011000)     op_cls = OP_SUB;
    else if (opcode == 11'b10001010000)     op_cls = OP_AND;
    else if (opcode == 11'b10101010000)     op_cls = OP_ORR;
    else if (opcode[10:3] == 8'b10110100)   op_cls = OP_CBZ;
    else if (opcode[10:5] == 6'b000101)     op_cls = OP_B;
  end

  always_comb begin
    alu_r = ALU_ADD;
    case (op_cls)
      OP_SUB:  alu_r = ALU_SUB;
      OP_AND:  alu_r = ALU_AND;
      OP_ORR:  alu_r = ALU_ORR;
      default: alu_r = ALU_ADD;
    endcase
  end

  // Moore decode from state; only the memory handshake and the branch flag qualify enables.
  always_comb begin
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    IRWrite    = 1'b0;
    Reg2Loc    = 1'b0;
    AluSrc     = 1'b0;
    AluControl = ALU_AND;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_EXEC_R: AluControl = alu_r;
      S_WB_R: begin
        AluControl = alu_r;
        RegWrite   = 1'b1;
      end
      S_ADDR: begin
        AluSrc     = 1'b1;
        AluControl = ALU_ADD;
        Reg2Loc    = (op_cls == OP_STUR);
      end
      S_MEM_RD: begin
        mem_req    = 1'b1;
        MemRead    = 1'b1;
        AluSrc     = 1'b1;
        AluControl = ALU_ADD;
      end
      S_WB_LD: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        MemWrite   = 1'b1;
        Reg2Loc    = 1'b1;
        AluSrc     = 1'b1;
        AluControl = ALU_ADD;
      end
      S_CB: begin
        Reg2Loc    = 1'b1;
        AluControl = ALU_PASS;
        PCWrite    = zero_E;
        PCSrc      = 1'b1;
      end
      S_UB: begin
        PCWrite = 1'b1;
        PCSrc   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    cause_d = cause_q;
    retire  = 1'b0;
    tmo_d   = (mem_req && !mem_ready) ? tmo_q + TMO_W'(1) : '0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op_cls)
          OP_ADD, OP_SUB, OP_AND, OP_ORR: state_d = S_EXEC_R;
          OP_LDUR, OP_STUR:               state_d = S_ADDR;
          OP_CBZ:                         state_d = S_CB;
          OP_B:                           state_d = S_UB;
          default: begin
            state_d = S_EXC;
            exc_d   = 1'b1;
            cause_d = 2'b01;
          end
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_ADDR:   state_d = (op_cls == OP_STUR) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_d = S_WB_LD;
      S_MEM_WR: if (mem_ready) begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_WB_R, S_WB_LD, S_CB, S_UB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXC:    state_d = S_EXC;
      default:  state_d = S_IDLE;
    endcase
    // A ready on the last allowed cycle completes the access, so only a missing ready times out.
    if (mem_req && !mem_ready && tmo_q == TMO_LAST) begin
      state_d = S_EXC;
      exc_d   = 1'b1;
      cause_d = 2'b10;
      tmo_d   = '0;
    end
    retire_d = retire_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      exc_q    <= 1'b0;
      cause_q  <= 2'b00;
      retire_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      exc_q    <= exc_d;
      cause_q  <= cause_d;
      retire_q <= retire_d;
    end
  end

  assign exc          = exc_q;
  assign exc_cause    = cause_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle vector table, hand-written corner sequences and a
// randomized instruction stream checked against latency/enable-count arithmetic.
module tb_multicycle_ctrl;

  localparam int MT = 16;
  localparam int CW = 32;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100011;
  localparam logic [10:0] OP_B    = 11'b00010110101;
  localparam logic [10:0] OP_ILL  = 11'b11111111111;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   opcode;
  logic          zero_E, mem_ready;
  logic          mem_req, PCWrite, PCSrc, IRWrite, Reg2Loc, AluSrc;
  logic [3:0]    AluControl;
  logic          MemRead, MemWrite, RegWrite, MemtoReg, exc;
  logic [1:0]    exc_cause;
  logic [CW-1:0] retire_count;
  logic [13:0]   act_cw;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero_E(zero_E), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .Reg2Loc(Reg2Loc),
    .AluSrc(AluSrc), .AluControl(AluControl), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .exc(exc), .exc_cause(exc_cause),
    .retire_count(retire_count)
  );

  assign act_cw = {mem_req, PCWrite, PCSrc, IRWrite, Reg2Loc, AluSrc, AluControl,
                   MemRead, MemWrite, RegWrite, MemtoReg};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] cw(input logic req, pcw, pcs, irw, r2l, asrc,
                                     input logic [3:0] alu, input logic mr, mw, rw, m2r);
    return {req, pcw, pcs, irw, r2l, asrc, alu, mr, mw, rw, m2r};
  endfunction

  typedef struct {
    string       name;
    logic [10:0] op;
    logic        z;
    logic        rdy;
    logic [13:0] ecw;
    logic [2:0]  eex;
    int          eret;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input logic [10:0] op, input logic z, input logic rdy);
    @(negedge clk);
    opcode    = op;
    zero_E    = z;
    mem_ready = rdy;
    #1;
  endtask

  task automatic cyc(input string n, input logic [10:0] op, input logic z, input logic rdy,
                     input logic [13:0] ecw, input logic [2:0] eex, input int eret);
    drive(op, z, rdy);
    check({n, "_ctl"}, 32'(act_cw), 32'(ecw));
    check({n, "_exc"}, 32'({exc, exc_cause}), 32'(eex));
    check({n, "_ret"}, retire_count, 32'(eret));
  endtask

  task automatic add(input string n, input logic [10:0] op, input logic z, input logic rdy,
                     input logic [13:0] ecw, input logic [2:0] eex, input int eret);
    tbl.push_back('{n, op, z, rdy, ecw, eex, eret});
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) cyc(tbl[i].name, tbl[i].op, tbl[i].z, tbl[i].rdy, tbl[i].ecw, tbl[i].eex, tbl[i].eret);
    tbl.delete();
  endtask

  // Expected rows for one instruction at zero fetch wait; mem_ready=1 outside accesses is noise.
  task automatic push_front(input string t, input logic [10:0] op, input logic z, input int r);
    add({t, "_fetch"}, op, z, 1'b1, cw(1,1,0,1,0,0,4'b0000,1,0,0,0), 3'b000, r);
    add({t, "_dec"},   op, z, 1'b1, 14'h0, 3'b000, r);
  endtask

  task automatic push_r(input string t, input logic [10:0] op, input logic [3:0] alu, input int r);
    push_front(t, op, 1'b0, r);
    add({t, "_exec"}, op, 1'b0, 1'b1, cw(0,0,0,0,0,0,alu,0,0,0,0), 3'b000, r);
    add({t, "_wb"},   op, 1'b0, 1'b1, cw(0,0,0,0,0,0,alu,0,0,1,0), 3'b000, r);
  endtask

  task automatic push_ld(input string t, input int waits, input int r);
    push_front(t, OP_LDUR, 1'b0, r);
    add({t, "_addr"}, OP_LDUR, 1'b0, 1'b1, cw(0,0,0,0,0,1,4'b0010,0,0,0,0), 3'b000, r);
    for (int w = 0; w < waits; w++)
      add($sformatf("%s_rdwait%0d", t, w), OP_LDUR, 1'b0, 1'b0, cw(1,0,0,0,0,1,4'b0010,1,0,0,0), 3'b000, r);
    add({t, "_rd"}, OP_LDUR, 1'b0, 1'b1, cw(1,0,0,0,0,1,4'b0010,1,0,0,0), 3'b000, r);
    add({t, "_wb"}, OP_LDUR, 1'b0, 1'b1, cw(0,0,0,0,0,0,4'b0000,0,0,1,1), 3'b000, r);
  endtask

  task automatic push_st(input string t, input int r);
    push_front(t, OP_STUR, 1'b0, r);
    add({t, "_addr"}, OP_STUR, 1'b0, 1'b1, cw(0,0,0,0,1,1,4'b0010,0,0,0,0), 3'b000, r);
    add({t, "_wr"},   OP_STUR, 1'b0, 1'b1, cw(1,0,0,0,1,1,4'b0010,0,1,0,0), 3'b000, r);
  endtask

  task automatic push_cb(input string t, input logic z, input int r);
    push_front(t, OP_CBZ, z, r);
    add({t, "_cb"}, OP_CBZ, z, 1'b1, cw(0,z,1,0,1,0,4'b0111,0,0,0,0), 3'b000, r);
  endtask

  task automatic push_b(input string t, input int r);
    push_front(t, OP_B, 1'b0, r);
    add({t, "_ub"}, OP_B, 1'b0, 1'b1, cw(0,1,1,0,0,0,4'b0000,0,0,0,0), 3'b000, r);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    opcode    = '0;
    zero_E    = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_low_ctl", 32'(act_cw), 32'h0);
    check("rst_low_exc", 32'({exc, exc_cause}), 32'h0);
    check("rst_low_ret", retire_count, 32'h0);
    reset = 1'b1;
    #1;
    check("idle_ctl", 32'(act_cw), 32'h0);
  endtask

  function automatic logic [10:0] rnd_op(input int cls);
    logic [10:0] r;
    r = 11'($urandom);
    case (cls)
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_AND;
      3: return OP_ORR;
      4: return OP_LDUR;
      5: return OP_STUR;
      6: return {8'b10110100, r[2:0]};
      default: return {6'b000101, r[4:0]};
    endcase
  endfunction

  function automatic logic [3:0] wb_alu(input int cls);
    case (cls)
      0: return 4'b0010;
      1: return 4'b0110;
      2: return 4'b0000;
      3: return 4'b0001;
      default: return 4'hF;
    endcase
  endfunction

  initial begin
    reset = 1'b1; opcode = '0; zero_E = 1'b0; mem_ready = 1'b0;
    #1;

    // Table: one of each instruction at zero memory wait, back to back.
    do_reset();
    push_r("add", OP_ADD, 4'b0010, 0);
    push_r("sub", OP_SUB, 4'b0110, 1);
    push_r("and", OP_AND, 4'b0000, 2);
    push_r("orr", OP_ORR, 4'b0001, 3);
    push_ld("ldur", 0, 4);
    push_st("stur", 5);
    push_cb("cbz_t", 1'b1, 6);
    push_cb("cbz_n", 1'b0, 7);
    push_b("b", 8);
    add("tail_fetch", OP_ADD, 1'b0, 1'b0, cw(1,0,0,0,0,0,4'b0000,1,0,0,0), 3'b000, 9);
    run_tbl();

    // LDUR with three data wait cycles: eight cycles to retire.
    do_reset();
    push_ld("ld3", 3, 0);
    add("ld3_next", OP_ADD, 1'b0, 1'b1, cw(1,1,0,1,0,0,4'b0000,1,0,0,0), 3'b000, 1);
    run_tbl();

    // Illegal opcode: exception after DECODE, held for 20 cycles, nothing retires.
    do_reset();
    add("ill_fetch", OP_ILL, 1'b0, 1'b1, cw(1,1,0,1,0,0,4'b0000,1,0,0,0), 3'b000, 0);
    add("ill_dec",   OP_ILL, 1'b0, 1'b0, 14'h0, 3'b000, 0);
    run_tbl();
    for (int i = 0; i < 20; i++)
      cyc($sformatf("ill_exc%0d", i), OP_ILL, 1'($urandom), 1'($urandom), 14'h0, 3'b101, 0);

    // Fetch timeout: 16 request cycles without ready, then EXC with cause 10.
    do_reset();
    for (int i = 0; i < MT; i++)
      cyc($sformatf("tmo_f%0d", i), OP_ADD, 1'b0, 1'b0, cw(1,0,0,0,0,0,4'b0000,1,0,0,0), 3'b000, 0);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("tmo_exc%0d", i), OP_ADD, 1'b0, 1'b1, 14'h0, 3'b110, 0);

    // Ready on the 16th request cycle wins: the fetch completes.
    do_reset();
    for (int i = 0; i < MT - 1; i++)
      cyc($sformatf("edge_f%0d", i), OP_ADD, 1'b0, 1'b0, cw(1,0,0,0,0,0,4'b0000,1,0,0,0), 3'b000, 0);
    cyc("edge_fok", OP_ADD, 1'b0, 1'b1, cw(1,1,0,1,0,0,4'b0000,1,0,0,0), 3'b000, 0);
    add("edge_dec",  OP_ADD, 1'b0, 1'b0, 14'h0, 3'b000, 0);
    add("edge_exec", OP_ADD, 1'b0, 1'b0, cw(0,0,0,0,0,0,4'b0010,0,0,0,0), 3'b000, 0);
    add("edge_wb",   OP_ADD, 1'b0, 1'b0, cw(0,0,0,0,0,0,4'b0010,0,0,1,0), 3'b000, 0);
    add("edge_next", OP_ADD, 1'b0, 1'b0, cw(1,0,0,0,0,0,4'b0000,1,0,0,0), 3'b000, 1);
    run_tbl();

    // Data-write timeout also raises cause 10 without retiring the store.
    do_reset();
    push_front("wtmo", OP_STUR, 1'b0, 0);
    add("wtmo_addr", OP_STUR, 1'b0, 1'b0, cw(0,0,0,0,1,1,4'b0010,0,0,0,0), 3'b000, 0);
    run_tbl();
    for (int i = 0; i < MT; i++)
      cyc($sformatf("wtmo_wr%0d", i), OP_STUR, 1'b0, 1'b0, cw(1,0,0,0,1,1,4'b0010,0,1,0,0), 3'b000, 0);
    cyc("wtmo_exc", OP_STUR, 1'b0, 1'b1, 14'h0, 3'b110, 0);

    // Reset mid-MEM_WR: request drops at once, counters clear, fetch resumes.
    do_reset();
    push_r("pre", OP_ADD, 4'b0010, 0);
    push_front("mw", OP_STUR, 1'b0, 1);
    add("mw_addr", OP_STUR, 1'b0, 1'b0, cw(0,0,0,0,1,1,4'b0010,0,0,0,0), 3'b000, 1);
    add("mw_wr0",  OP_STUR, 1'b0, 1'b0, cw(1,0,0,0,1,1,4'b0010,0,1,0,0), 3'b000, 1);
    run_tbl();
    #2 reset = 1'b0;
    #1;
    check("mw_rst_req", 32'(mem_req), 32'h0);
    check("mw_rst_ctl", 32'(act_cw), 32'h0);
    check("mw_rst_ret", retire_count, 32'h0);
    do_reset();
    push_r("post", OP_ADD, 4'b0010, 0);
    add("post_next", OP_ADD, 1'b0, 1'b0, cw(1,0,0,0,0,0,4'b0000,1,0,0,0), 3'b000, 1);
    run_tbl();

    // Random stream: latency and per-instruction enable counts from instruction-level arithmetic.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      int cls, fw, dw, lat, ds;
      int n_req, n_rw, n_pcw, n_m2r, n_irw, n_mw, n_exc;
      logic        zb, rdy, zz, is_mem;
      logic [10:0] op;
      logic [3:0]  alu_seen;
      cls = $urandom_range(0, 7);
      op  = rnd_op(cls);
      zb  = 1'($urandom);
      fw  = ($urandom_range(0, 7) == 0) ? MT - 1 : $urandom_range(0, 3);
      dw  = ($urandom_range(0, 7) == 0) ? MT - 1 : $urandom_range(0, 3);
      is_mem = (cls == 4 || cls == 5);
      ds  = fw + 3;
      case (cls)
        4:       lat = fw + dw + 5;
        5:       lat = fw + dw + 4;
        6, 7:    lat = fw + 3;
        default: lat = fw + 4;
      endcase
      n_req = 0; n_rw = 0; n_pcw = 0; n_m2r = 0; n_irw = 0; n_mw = 0; n_exc = 0;
      alu_seen = 4'hF;
      for (int i = 0; i < lat; i++) begin
        if (i <= fw)                          rdy = (i == fw);
        else if (is_mem && i >= ds && i <= ds + dw) rdy = (i == ds + dw);
        else                                  rdy = 1'($urandom);
        zz = (cls == 6) ? zb : 1'($urandom);
        drive(op, zz, rdy);
        if (i == 0) check($sformatf("rnd%0d_ret", k), retire_count, 32'(k));
        n_req += int'(mem_req);
        n_rw  += int'(RegWrite);
        n_pcw += int'(PCWrite);
        n_m2r += int'(MemtoReg);
        n_irw += int'(IRWrite);
        n_mw  += int'(MemWrite);
        n_exc += int'(exc);
        if (RegWrite && !MemtoReg) alu_seen = AluControl;
      end
      check($sformatf("rnd%0d_req", k), 32'(n_req), 32'(fw + 1 + (is_mem ? dw + 1 : 0)));
      check($sformatf("rnd%0d_rw", k),  32'(n_rw),  32'((cls <= 4) ? 1 : 0));
      check($sformatf("rnd%0d_pcw", k), 32'(n_pcw), 32'(1 + ((cls == 7 || (cls == 6 && zb)) ? 1 : 0)));
      check($sformatf("rnd%0d_m2r", k), 32'(n_m2r), 32'((cls == 4) ? 1 : 0));
      check($sformatf("rnd%0d_irw", k), 32'(n_irw), 32'h1);
      check($sformatf("rnd%0d_mw", k),  32'(n_mw),  32'((cls == 5) ? dw + 1 : 0));
      check($sformatf("rnd%0d_exc", k), 32'(n_exc), 32'h0);
      check($sformatf("rnd%0d_alu", k), 32'(alu_seen), 32'(wb_alu(cls)));
    end
    drive(OP_ADD, 1'b0, 1'b0);
    check("rnd_final_ret", retire_count, 32'd40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
